// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S shift engine: slot/frame geometry and FSM states.
package i2s_pkg;

  localparam int unsigned SLOT_WIDTH = 32;
  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned F_W        = $clog2(FRAME_BITS);
  localparam int unsigned LEFT_MSB   = FRAME_BITS - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generator with frame counter; all state clears while run_i is low.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           run_i,
  output logic           bclk_o,
  output logic           lrclk_o,
  output logic           bclk_rise_c_o,
  output logic           bclk_fall_c_o,
  output logic [F_W-1:0] frame_cnt_o
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV + 1);

  logic [DIV_W-1:0] div_q;
  logic             bclk_q;
  logic             lrclk_q;
  logic [F_W-1:0]   f_q;
  logic [F_W-1:0]   f_next;
  logic             tc;

  // Edge strobes fire in the cycle whose clock edge flips bclk_q.
  assign tc            = (div_q == DIV_W'(BCLK_DIV - 1));
  assign bclk_rise_c_o = run_i & tc & ~bclk_q;
  assign bclk_fall_c_o = run_i & tc & bclk_q;
  assign f_next        = f_q + F_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      f_q     <= '0;
    end else if (!run_i) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      f_q     <= '0;
    end else begin
      div_q <= tc ? '0 : div_q + DIV_W'(1);
      if (tc) begin
        bclk_q <= ~bclk_q;
      end
      if (bclk_fall_c_o) begin
        f_q     <= f_next;
        lrclk_q <= f_next[F_W-1];
      end
    end
  end

  assign bclk_o      = bclk_q;
  assign lrclk_o     = lrclk_q;
  assign frame_cnt_o = f_q;

endmodule

// File: rtl/i2s_shift_engine.sv
// I2S master serializer/deserializer: one 64-bit stereo word per frame to/from the bridge FIFOs,
// handshaked with fixed-width hold-then-release strobes.
module i2s_shift_engine
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV    = 4,
  parameter int unsigned STROBE_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  playback_enable,
  input  logic                  capture_enable,
  input  logic [FRAME_BITS-1:0] playback_fifo_data,
  output logic                  playback_fifo_ack,
  output logic [FRAME_BITS-1:0] capture_fifo_data,
  output logic                  capture_fifo_write,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_dout,
  input  logic                  i2s_din
);

  localparam int unsigned HOLD_W = $clog2(STROBE_HOLD + 1);

  state_e                state_q;
  logic                  run;
  logic                  bclk_rise;
  logic                  bclk_fall;
  logic [F_W-1:0]        frame_cnt;
  logic                  frame_start;
  logic                  word_done;
  logic                  cap_act_q;
  logic                  dout_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] rx_q;
  logic [FRAME_BITS-1:0] rx_word;
  logic [FRAME_BITS-1:0] cap_data_q;
  logic                  ack_q;
  logic                  wr_q;
  logic [HOLD_W-1:0]     ack_cnt_q;
  logic [HOLD_W-1:0]     wr_cnt_q;

  assign run = (state_q == RUN);

  i2s_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .run_i        (run),
    .bclk_o       (i2s_bclk),
    .lrclk_o      (i2s_lrclk),
    .bclk_rise_c_o(bclk_rise),
    .bclk_fall_c_o(bclk_fall),
    .frame_cnt_o  (frame_cnt)
  );

  // Frame starts on the fall closing period 0; the RX word closes on the rise inside period 0.
  assign frame_start = bclk_fall && (frame_cnt == '0);
  assign rx_word     = {rx_q[FRAME_BITS-2:0], i2s_din};
  assign word_done   = bclk_rise && (frame_cnt == '0) && cap_act_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cap_act_q <= 1'b0;
      dout_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else if (state_q == IDLE) begin
      cap_act_q <= 1'b0;
      dout_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      if (playback_enable || capture_enable) begin
        state_q <= RUN;
      end
    end else begin
      if (bclk_rise) begin
        rx_q <= rx_word;
      end
      if (frame_start) begin
        cap_act_q <= capture_enable;
        if (!playback_enable && !capture_enable) begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          tx_q    <= '0;
        end else if (playback_enable) begin
          dout_q <= playback_fifo_data[LEFT_MSB];
          tx_q   <= {playback_fifo_data[FRAME_BITS-2:0], 1'b0};
        end else begin
          dout_q <= 1'b0;
          tx_q   <= '0;
        end
      end else if (bclk_fall) begin
        dout_q <= tx_q[FRAME_BITS-1];
        tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Strobes run to completion independently of the FSM so IDLE never truncates them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      ack_cnt_q  <= '0;
      wr_q       <= 1'b0;
      wr_cnt_q   <= '0;
      cap_data_q <= '0;
    end else begin
      if (run && frame_start && playback_enable) begin
        ack_q     <= 1'b1;
        ack_cnt_q <= HOLD_W'(STROBE_HOLD - 1);
      end else if (ack_q) begin
        if (ack_cnt_q == '0) begin
          ack_q <= 1'b0;
        end else begin
          ack_cnt_q <= ack_cnt_q - HOLD_W'(1);
        end
      end
      if (run && word_done) begin
        wr_q       <= 1'b1;
        wr_cnt_q   <= HOLD_W'(STROBE_HOLD - 1);
        cap_data_q <= rx_word;
      end else if (wr_q) begin
        if (wr_cnt_q == '0) begin
          wr_q <= 1'b0;
        end else begin
          wr_cnt_q <= wr_cnt_q - HOLD_W'(1);
        end
      end
    end
  end

  assign playback_fifo_ack  = ack_q;
  assign capture_fifo_write = wr_q;
  assign capture_fifo_data  = cap_data_q;
  assign i2s_dout           = dout_q;

endmodule

// File: tb/tb_i2s_shift_engine.sv
// Self-checking bench for i2s_shift_engine: serial bit table, loopback scoreboard, idle/reset corners,
// and a second instance at the minimum divider/hold.
module tb_i2s_shift_engine;

  localparam int unsigned DIV0  = 2;
  localparam int unsigned HOLD0 = 4;
  localparam int unsigned DIV1  = 1;
  localparam int unsigned HOLD1 = 2;
  localparam logic [63:0] WT = 64'hA5A5_0001_8000_00FF;
  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] W2 = 64'h5A5A_F00F_1234_8001;
  localparam logic [63:0] W3 = 64'hC3C3_5A5A_0F0F_F0F0;
  localparam logic [63:0] WL = 64'h0000_0001_FFFF_FFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        pb_en, cap_en;
  logic [63:0] pb_data;
  logic        ack, wr, bclk, lrclk, dout, din;
  logic [63:0] cap_data;
  logic [1:0]  din_sel;
  assign din = (din_sel == 2'd0) ? dout : (din_sel == 2'd1) ? lrclk : 1'b0;

  logic        en1, ack1, wr1, bclk1, lr1, dout1;
  logic [63:0] cap1;

  i2s_shift_engine #(.BCLK_DIV(DIV0), .STROBE_HOLD(HOLD0)) dut (
    .clk(clk), .reset_n(reset_n),
    .playback_enable(pb_en), .capture_enable(cap_en),
    .playback_fifo_data(pb_data), .playback_fifo_ack(ack),
    .capture_fifo_data(cap_data), .capture_fifo_write(wr),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_dout(dout), .i2s_din(din)
  );

  i2s_shift_engine #(.BCLK_DIV(DIV1), .STROBE_HOLD(HOLD1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .playback_enable(en1), .capture_enable(en1),
    .playback_fifo_data(W3), .playback_fifo_ack(ack1),
    .capture_fifo_data(cap1), .capture_fifo_write(wr1),
    .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_dout(dout1), .i2s_din(dout1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor state for the main instance
  logic        bclk_p = 1'b0, ack_p = 1'b0, wr_p = 1'b0;
  int          ack_w = 0, wr_w = 0, ack_pulses = 0, wr_pulses = 0, rises = 0;
  int          cyc = 0, last_wr = -1;
  bit          samp_en = 1'b0, chk_en = 1'b0, per_en = 1'b0;
  logic        dout_seen = 1'b0;
  logic        sd[$];
  logic        sl[$];
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    dout_seen = dout_seen | dout;
    if (bclk && !bclk_p) begin
      rises++;
      if (samp_en) begin
        sd.push_back(dout);
        sl.push_back(lrclk);
      end
    end
    if (ack && !ack_p) begin
      ack_pulses++;
      if (chk_en) check("ack_at_bclk_fall", 64'({bclk_p, bclk}), 64'd2);
    end
    if (ack) ack_w++;
    else begin
      if (ack_p && chk_en) check("ack_width", 64'(ack_w), 64'(HOLD0));
      ack_w = 0;
    end
    if (wr && !wr_p) begin
      wr_pulses++;
      if (chk_en) begin
        check("wr_at_bclk_rise", 64'({bclk_p, bclk}), 64'd1);
        check("wr_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("cap_data", cap_data, exp_q.pop_front());
        if (per_en && last_wr >= 0) check("wr_interval", 64'(cyc - last_wr), 64'(128 * DIV0));
      end
      last_wr = cyc;
    end
    if (wr) wr_w++;
    else begin
      if (wr_p && chk_en) check("wr_width", 64'(wr_w), 64'(HOLD0));
      wr_w = 0;
    end
    if (!reset_n) begin
      ack_w = 0;
      wr_w  = 0;
    end
    bclk_p = bclk;
    ack_p  = ack;
    wr_p   = wr;
  end

  // Monitor for the minimum-divider instance
  logic b1_p = 1'b0, a1_p = 1'b0, w1_p = 1'b0;
  int   last_r1 = -1, last_a1 = -1, last_w1 = -1, a1_w = 0, wr1_pulses = 0;

  always @(posedge clk) begin
    #1;
    if (bclk1 && !b1_p) begin
      if (last_r1 >= 0 && en1) check("bclk1_period", 64'(cyc - last_r1), 64'(2 * DIV1));
      last_r1 = cyc;
    end
    if (ack1 && !a1_p) begin
      if (last_a1 >= 0) check("ack1_interval", 64'(cyc - last_a1), 64'(128 * DIV1));
      last_a1 = cyc;
    end
    if (ack1) a1_w++;
    else begin
      if (a1_p) check("ack1_width", 64'(a1_w), 64'(HOLD1));
      a1_w = 0;
    end
    if (wr1 && !w1_p) begin
      wr1_pulses++;
      check("cap1_data", cap1, W3);
      if (last_w1 >= 0) check("wr1_interval", 64'(cyc - last_w1), 64'(128 * DIV1));
      last_w1 = cyc;
    end
    b1_p = bclk1;
    a1_p = ack1;
    w1_p = wr1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int n);
    int t = 0;
    while (ack_pulses < n && t < 5000) begin step(); t++; end
    check("wait_ack", 64'(ack_pulses >= n), 64'd1);
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_pulses < n && t < 5000) begin step(); t++; end
    check("wait_wr", 64'(wr_pulses >= n), 64'd1);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (rises < n && t < 5000) begin step(); t++; end
    check("wait_rises", 64'(rises >= n), 64'd1);
  endtask

  task automatic wait_wr1(input int n);
    int t = 0;
    while (wr1_pulses < n && t < 5000) begin step(); t++; end
    check("wait_wr1", 64'(wr1_pulses >= n), 64'd1);
  endtask

  task automatic check_quiet(input int ncyc, input string nm);
    logic acc = 1'b0;
    repeat (ncyc) begin
      step();
      acc = acc | bclk | lrclk | dout | ack | wr;
    end
    check(nm, 64'(acc), 64'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_bclk"}, 64'(bclk), 64'd0);
    check({nm, "_lrclk"}, 64'(lrclk), 64'd0);
    check({nm, "_dout"}, 64'(dout), 64'd0);
    check({nm, "_ack"}, 64'(ack), 64'd0);
    check({nm, "_wr"}, 64'(wr), 64'd0);
    check({nm, "_capdata"}, cap_data, 64'd0);
  endtask

  typedef struct {
    int   k;
    logic d;
    logic l;
  } vec_t;
  vec_t vt[14];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ab, wb, r0;
    // Period index since leaving IDLE, expected dout, expected lrclk for word WT
    vt[0]  = '{0,  1'b0, 1'b0};
    vt[1]  = '{1,  1'b1, 1'b0};
    vt[2]  = '{2,  1'b0, 1'b0};
    vt[3]  = '{3,  1'b1, 1'b0};
    vt[4]  = '{4,  1'b0, 1'b0};
    vt[5]  = '{5,  1'b0, 1'b0};
    vt[6]  = '{6,  1'b1, 1'b0};
    vt[7]  = '{31, 1'b0, 1'b0};
    vt[8]  = '{32, 1'b1, 1'b1};
    vt[9]  = '{33, 1'b1, 1'b1};
    vt[10] = '{34, 1'b0, 1'b1};
    vt[11] = '{63, 1'b1, 1'b1};
    vt[12] = '{64, 1'b1, 1'b0};
    vt[13] = '{65, 1'b1, 1'b0};

    reset_n = 1'b0; pb_en = 1'b0; cap_en = 1'b0; pb_data = '0; din_sel = 2'd0; en1 = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    check_quiet(20, "idle_after_reset");

    // Playback-only serial bit order
    chk_en = 1'b1; samp_en = 1'b1;
    pb_data = WT; pb_en = 1'b1;
    wait_rises(66);
    samp_en = 1'b0;
    check("sample_count", 64'(sd.size() >= 66), 64'd1);
    if (sd.size() >= 66) begin
      foreach (vt[i]) begin
        check($sformatf("dout_k%0d", vt[i].k), 64'(sd[vt[i].k]), 64'(vt[i].d));
        check($sformatf("lrclk_k%0d", vt[i].k), 64'(sl[vt[i].k]), 64'(vt[i].l));
      end
    end
    check("ack_count_t1", 64'(ack_pulses), 64'd2);
    check("wr_count_t1", 64'(wr_pulses), 64'd0);
    pb_en = 1'b0;
    repeat (300) step();
    check_quiet(50, "idle_after_t1");

    // Loopback scoreboard, then drop enables mid-frame
    ab = ack_pulses; wb = wr_pulses;
    din_sel = 2'd0;
    pb_data = W0; exp_q.push_back(W0);
    pb_en = 1'b1; cap_en = 1'b1;
    wait_ack(ab + 1);
    repeat (HOLD0 + 1) step();
    pb_data = W1; exp_q.push_back(W1);
    wait_ack(ab + 2);
    repeat (HOLD0 + 1) step();
    pb_data = W2; exp_q.push_back(W2);
    wait_ack(ab + 3);
    wait_rises(rises + 10);
    pb_en = 1'b0; cap_en = 1'b0;
    wait_wr(wb + 3);
    repeat (HOLD0 + 6) step();
    check_quiet(300, "idle_after_drop");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("wr_count_t3", 64'(wr_pulses - wb), 64'd3);
    check("ack_count_t3", 64'(ack_pulses - ab), 64'd3);

    // Capture-only with din = lrclk
    ab = ack_pulses; wb = wr_pulses;
    din_sel = 2'd1; per_en = 1'b1; last_wr = -1; dout_seen = 1'b0;
    repeat (3) exp_q.push_back(WL);
    cap_en = 1'b1;
    wait_wr(wb + 3);
    per_en = 1'b0;
    check("ack_none_t4", 64'(ack_pulses - ab), 64'd0);
    check("dout_zero_t4", 64'(dout_seen), 64'd0);
    check("scoreboard_empty_t4", 64'(exp_q.size()), 64'd0);

    // Reset while ack is high, then restart from f=0
    cap_en = 1'b0; pb_en = 1'b1; pb_data = WT;
    wait_ack(ab + 1);
    check("ack_high_before_reset", 64'(ack), 64'd1);
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) step();
    sd.delete(); sl.delete();
    samp_en = 1'b1; chk_en = 1'b1;
    r0 = rises;
    reset_n = 1'b1;
    wait_rises(r0 + 34);
    samp_en = 1'b0;
    check("restart_samples", 64'(sd.size() >= 34), 64'd1);
    if (sd.size() >= 34) begin
      check("restart_dout_f0", 64'(sd[0]), 64'd0);
      check("restart_dout_f1", 64'(sd[1]), 64'd1);
      check("restart_lr_f31", 64'(sl[31]), 64'd0);
      check("restart_lr_f32", 64'(sl[32]), 64'd1);
    end
    pb_en = 1'b0;
    repeat (300) step();
    check_quiet(20, "idle_after_t5");

    // Minimum divider and hold
    en1 = 1'b1;
    wait_wr1(3);
    en1 = 1'b0;
    repeat (300) step();
    check("dut1_idle_bclk", 64'(bclk1), 64'd0);
    check("dut1_idle_ack", 64'(ack1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
